data_memory_unit: RTL and testbench
===================================

// Module: data_memory_unit
// PURPOSE
//  Wait-state data memory that sits directly downstream of the datapath's data port.
//  It replaces the bench-level array behind dataMemAddress/dataMemRead/dataMemWrite.
//  Decodes the .data window at BASE_ADDR, applies byte-lane writes and flags
//  misaligned or out-of-range accesses for the datapath's exception logic.
//  Returns data after a programmable latency with a ready pulse; the datapath stalls PC until ready.
// PARAMETERS
//  BASE_ADDR    32'h10010000  byte address of word 0
//  DEPTH_WORDS  1024          number of 32-bit words stored
//  WAIT_CYCLES  2             wait states between request acceptance and completion (0 allowed)
// PORTS
//  clock         in   1   single clock, all state updates on posedge
//  resetn        in   1   asynchronous, active-low reset
//  memAddress    in   32  byte address from datapath
//  memRead       in   1   load request
//  memWrite      in   1   store request
//  writeValue    in   32  store data, lane-aligned (lane i = bits 8i+7:8i)
//  byteEnable    in   4   write lanes: 1111 word, 0011/1100 half, one-hot byte
//  readValue     out  32  full word at decoded index; sign/zero extension is done by the datapath
//  ready         out  1   one-cycle completion pulse
//  addressError  out  1   coincident with ready; access was illegal and not performed
//  busy          out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, wait counter=0, readValue=0, ready=0,
//    addressError=0, busy=0. Memory array is NOT cleared.
//  FSM states IDLE, WAIT, DONE:
//   IDLE: if memRead|memWrite at posedge, latch address, data, byteEnable and
//     request type, then evaluate legality.
//     Illegal -> DONE with error.
//     Legal with WAIT_CYCLES>0 -> WAIT with counter=0.
//     Legal with WAIT_CYCLES=0 -> DONE.
//   WAIT: counter increments each cycle; at counter==WAIT_CYCLES-1, go to DONE.
//     Store commits on this edge (the edge entering DONE). Load data is latched
//     into readValue on this same edge.
//   DONE: ready=1 for exactly one cycle; unconditionally return to IDLE.
//  Latency: request present in cycle 0 (IDLE) -> ready high in cycle WAIT_CYCLES+1.
//  Inputs are ignored outside IDLE. The requester holds the request stable until
//    it sees ready; a new request is sampled only in the first IDLE cycle after DONE.
//  Decode: offset = memAddress - BASE_ADDR (32-bit unsigned); index = offset[31:2].
//  Out of range when memAddress < BASE_ADDR or offset >= DEPTH_WORDS*4.
//  Misaligned:
//   - word (1111) requires addr[1:0]=00;
//   - half (0011/1100) requires addr[0]=0 and the upper lane pair iff addr[1]=1;
//   - byte (one-hot) requires the lane index to equal addr[1:0];
//   - any other byteEnable pattern on a store is illegal.
//   Loads check alignment only against word granularity (addr[1:0]=00 when byteEnable=1111).
//  memRead and memWrite both high in IDLE: illegal.
//  On error: memory unchanged, readValue=0, addressError=1 and ready=1 in DONE.
//  Store: only enabled lanes are updated; other lanes keep old value.
//  readValue holds its last value until the next completed load or error, or until reset.
//  Reset mid-operation (WAIT or DONE): aborts immediately, no ready pulse.
//    A store not yet committed never reaches memory.
// TESTING
//  1 WAIT_CYCLES=2: store 32'hDEADBEEF at 10010004, byteEnable 1111 -> ready in cycle 3,
//    addressError=0, word[1]=DEADBEEF; a load from the same address returns readValue=DEADBEEF in cycle 3.
//  2 Store 32'h00AA0000 at 10010006 with byteEnable 0100 over DEADBEEF -> word[1]=DEAABEEF,
//    other lanes untouched.
//  3 Word store at 10010002 -> ready=1 and addressError=1 in cycle 1 (no wait states);
//    word[0] unchanged.
//  4 Load from 10011000 and from 1000FFFC -> each ready+addressError in cycle 1, readValue=0.
//  5 Assert resetn=0 during WAIT of a store to 10010008 -> busy=0 and ready=0 immediately,
//    word[2] unchanged; a later store succeeds.
//  6 WAIT_CYCLES=0: back-to-back store/load pairs complete with ready in cycle 1 each.
//    memRead=memWrite=1 -> addressError.

Source files
------------

// File: rtl/data_memory_unit.sv
// data_memory_unit: wait-state data memory behind the datapath's data port.
// Decodes the .data window at BASE_ADDR, performs byte-lane stores, returns
// load data after WAIT_CYCLES wait states with a one-cycle ready pulse, and
// flags out-of-range or misaligned accesses instead of performing them.
module data_memory_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] memAddress,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] writeValue,
  input  logic [3:0]  byteEnable,
  output logic [31:0] readValue,
  output logic        ready,
  output logic        addressError,
  output logic        busy
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [31:0]   LIMIT      = 32'(DEPTH_WORDS * 4);
  localparam logic [CW-1:0] LAST_COUNT = CW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          nextState_s;
  logic [CW-1:0]   waitCount_r;
  logic [CW-1:0]   nextCount_s;

  // request captured in IDLE; only consulted while waiting
  logic [IW-1:0]   index_r;
  logic [31:0]     data_r;
  logic [3:0]      be_r;
  logic            isWrite_r;

  logic [31:0]     readValue_r;
  logic            ready_r;
  logic            addressError_r;
  logic            busy_r;

  logic            request_s;
  logic [31:0]     offset_s;
  logic            outOfRange_s;
  logic            misaligned_s;
  logic            illegal_s;
  logic            complete_s;
  logic            error_s;

  logic [IW-1:0]   commitIndex_s;
  logic [31:0]     commitData_s;
  logic [3:0]      commitBe_s;
  logic            commitWrite_s;

  logic [31:0]     mem_r [0:DEPTH_WORDS-1];

  // Address decode and legality of the request currently on the inputs
  always_comb begin
    request_s    = memRead | memWrite;
    offset_s     = memAddress - BASE_ADDR;
    outOfRange_s = (memAddress < BASE_ADDR) || (offset_s >= LIMIT);
    misaligned_s = 1'b0;
    if (memWrite) begin
      case (byteEnable)
        4'b1111: misaligned_s = (memAddress[1:0] != 2'b00);
        4'b0011: misaligned_s = (memAddress[1:0] != 2'b00);
        4'b1100: misaligned_s = (memAddress[1:0] != 2'b10);
        4'b0001: misaligned_s = (memAddress[1:0] != 2'b00);
        4'b0010: misaligned_s = (memAddress[1:0] != 2'b01);
        4'b0100: misaligned_s = (memAddress[1:0] != 2'b10);
        4'b1000: misaligned_s = (memAddress[1:0] != 2'b11);
        default: misaligned_s = 1'b1;
      endcase
    end else begin
      // loads return the whole word, so only full-word requests need alignment
      misaligned_s = (byteEnable == 4'b1111) && (memAddress[1:0] != 2'b00);
    end
    illegal_s = (memRead && memWrite) || outOfRange_s || misaligned_s;
  end

  // FSM next state, wait counter and completion strobes
  always_comb begin
    nextState_s = state_r;
    nextCount_s = waitCount_r;
    complete_s  = 1'b0;
    error_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (request_s) begin
          if (illegal_s) begin
            nextState_s = ST_DONE;
            error_s     = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            nextState_s = ST_DONE;
            complete_s  = 1'b1;
          end else begin
            nextState_s = ST_WAIT;
            nextCount_s = {CW{1'b0}};
          end
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (waitCount_r == LAST_COUNT) begin
          nextState_s = ST_DONE;
          complete_s  = 1'b1;
        end else begin
          nextCount_s = waitCount_r + CW'(1);
        end
      end
      ST_DONE: begin
        nextState_s = ST_IDLE;
      end
      default: begin
        nextState_s = ST_IDLE;
      end
    endcase
  end

  // Completion uses live inputs when it happens straight from IDLE, else the captured request
  always_comb begin
    if (state_r == ST_IDLE) begin
      commitIndex_s = offset_s[IW+1:2];
      commitData_s  = writeValue;
      commitBe_s    = byteEnable;
      commitWrite_s = memWrite;
    end else begin
      commitIndex_s = index_r;
      commitData_s  = data_r;
      commitBe_s    = be_r;
      commitWrite_s = isWrite_r;
    end
  end

  // State, captured request and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      waitCount_r    <= {CW{1'b0}};
      index_r        <= {IW{1'b0}};
      data_r         <= 32'h0000_0000;
      be_r           <= 4'b0000;
      isWrite_r      <= 1'b0;
      readValue_r    <= 32'h0000_0000;
      ready_r        <= 1'b0;
      addressError_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r     <= nextState_s;
      waitCount_r <= nextCount_s;
      if ((state_r == ST_IDLE) && request_s) begin
        index_r   <= offset_s[IW+1:2];
        data_r    <= writeValue;
        be_r      <= byteEnable;
        isWrite_r <= memWrite;
      end
      ready_r        <= (nextState_s == ST_DONE);
      busy_r         <= (nextState_s != ST_IDLE);
      addressError_r <= error_s;
      if (error_s) begin
        readValue_r <= 32'h0000_0000;
      end else if (complete_s && !commitWrite_s) begin
        readValue_r <= mem_r[commitIndex_s];
      end
    end
  end

  // Storage array: lane-masked store on the edge entering DONE; contents survive reset
  always_ff @(posedge clock) begin
    if (resetn && complete_s && commitWrite_s) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (commitBe_s[lane]) begin
          mem_r[commitIndex_s][8*lane +: 8] <= commitData_s[8*lane +: 8];
        end
      end
    end
  end

  assign readValue    = readValue_r;
  assign ready        = ready_r;
  assign addressError = addressError_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: one instance with two wait states,
// one with none. Requests push their expected completion into a queue; a
// monitor per instance pops and compares whenever ready is seen.
module tb_data_memory_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic [31:0] addr2, wdata2, addr0, wdata0;
  logic        rd2, wr2, rd0, wr0;
  logic [3:0]  be2, be0;
  logic [31:0] rv2, rv0;
  logic        rdy2, rdy0, err2, err0, busy2, busy0;

  data_memory_unit #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u2 (
    .clock(clock), .resetn(resetn), .memAddress(addr2), .memRead(rd2), .memWrite(wr2),
    .writeValue(wdata2), .byteEnable(be2), .readValue(rv2), .ready(rdy2),
    .addressError(err2), .busy(busy2));

  data_memory_unit #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u0 (
    .clock(clock), .resetn(resetn), .memAddress(addr0), .memRead(rd0), .memWrite(wr0),
    .writeValue(wdata0), .byteEnable(be0), .readValue(rv0), .ready(rdy0),
    .addressError(err0), .busy(busy0));

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q2[$];
  exp_t        q0[$];
  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  logic [31:0] last2 = 32'h0;
  logic [31:0] last0 = 32'h0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor for the two-wait-state instance
  always @(negedge clock) begin : mon2
    exp_t e;
    if (resetn && rdy2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w2 unexpected ready: got ready=1 expected none pending");
      end else begin
        e = q2.pop_front();
        check({e.name, " cycle"}, cycle, e.cyc);
        check({e.name, " addressError"}, {31'h0, err2}, {31'h0, e.err});
        check({e.name, " readValue"}, rv2, e.data);
      end
    end
  end

  // monitor for the zero-wait-state instance
  always @(negedge clock) begin : mon0
    exp_t e;
    if (resetn && rdy0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w0 unexpected ready: got ready=1 expected none pending");
      end else begin
        e = q0.pop_front();
        check({e.name, " cycle"}, cycle, e.cyc);
        check({e.name, " addressError"}, {31'h0, err0}, {31'h0, e.err});
        check({e.name, " readValue"}, rv0, e.data);
      end
    end
  end

  // Issue one request on instance sel (2 or 0), push its expectation, hold until ready
  task automatic request(input int sel, input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] loadVal, input logic expErr);
    exp_t e;
    bit   got;
    @(negedge clock);
    e.name = name;
    e.err  = expErr;
    e.cyc  = cycle + (((sel == 2) && !expErr) ? 3 : 1);
    if (sel == 2) begin
      if (expErr) last2 = 32'h0;
      else if (rd && !wr) last2 = loadVal;
      e.data = last2;
      q2.push_back(e);
      addr2 = a; wdata2 = d; be2 = be; rd2 = rd; wr2 = wr;
    end else begin
      if (expErr) last0 = 32'h0;
      else if (rd && !wr) last0 = loadVal;
      e.data = last0;
      q0.push_back(e);
      addr0 = a; wdata0 = d; be0 = be; rd0 = rd; wr0 = wr;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      got = (sel == 2) ? rdy2 : rdy0;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no ready expected ready within 20 cycles", name);
    end
    if (sel == 2) begin rd2 = 1'b0; wr2 = 1'b0; end
    else begin rd0 = 1'b0; wr0 = 1'b0; end
  endtask

  initial begin
    resetn = 1'b0;
    addr2 = 32'h0; wdata2 = 32'h0; be2 = 4'h0; rd2 = 1'b0; wr2 = 1'b0;
    addr0 = 32'h0; wdata0 = 32'h0; be0 = 4'h0; rd0 = 1'b0; wr0 = 1'b0;
    repeat (3) @(negedge clock);
    check("reset readValue", rv2, 32'h0);
    check("reset ready", {31'h0, rdy2}, 32'h0);
    check("reset addressError", {31'h0, err2}, 32'h0);
    check("reset busy", {31'h0, busy2}, 32'h0);
    check("reset w0 busy/ready", {30'h0, busy0, rdy0}, 32'h0);
    resetn = 1'b1;

    // word store/load and byte-lane merge
    request(2, "st word1", 1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
    request(2, "ld word1", 1'b1, 1'b0, 32'h1001_0004, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    request(2, "st byte2", 1'b0, 1'b1, 32'h1001_0006, 32'h00AA_0000, 4'b0100, 32'h0, 1'b0);
    request(2, "ld merged", 1'b1, 1'b0, 32'h1001_0004, 32'h0, 4'b1111, 32'hDEAA_BEEF, 1'b0);

    // misaligned word store leaves word0 untouched
    request(2, "st word0", 1'b0, 1'b1, 32'h1001_0000, 32'h1234_5678, 4'b1111, 32'h0, 1'b0);
    request(2, "st misaligned", 1'b0, 1'b1, 32'h1001_0002, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
    request(2, "ld word0", 1'b1, 1'b0, 32'h1001_0000, 32'h0, 4'b1111, 32'h1234_5678, 1'b0);

    // range boundaries
    request(2, "ld above", 1'b1, 1'b0, 32'h1001_1000, 32'h0, 4'b1111, 32'h0, 1'b1);
    request(2, "st last word", 1'b0, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0);
    request(2, "ld last word", 1'b1, 1'b0, 32'h1001_0FFC, 32'h0, 4'b1111, 32'hCAFE_F00D, 1'b0);
    request(2, "ld below", 1'b1, 1'b0, 32'h1000_FFFC, 32'h0, 4'b1111, 32'h0, 1'b1);

    // half/byte lane rules
    request(2, "st half lo@2", 1'b0, 1'b1, 32'h1001_0002, 32'h0000_1111, 4'b0011, 32'h0, 1'b1);
    request(2, "st half hi@6", 1'b0, 1'b1, 32'h1001_0006, 32'h7766_0000, 4'b1100, 32'h0, 1'b0);
    request(2, "st byte0@5", 1'b0, 1'b1, 32'h1001_0005, 32'h0000_0011, 4'b0001, 32'h0, 1'b1);
    request(2, "st be 0101", 1'b0, 1'b1, 32'h1001_0004, 32'h0011_0011, 4'b0101, 32'h0, 1'b1);
    request(2, "ld byte@5", 1'b1, 1'b0, 32'h1001_0005, 32'h0, 4'b0001, 32'h7766_BEEF, 1'b0);
    request(2, "ld word@6", 1'b1, 1'b0, 32'h1001_0006, 32'h0, 4'b1111, 32'h0, 1'b1);

    // reset during the wait of a store aborts it
    request(2, "st word2", 1'b0, 1'b1, 32'h1001_0008, 32'h1122_3344, 4'b1111, 32'h0, 1'b0);
    @(negedge clock);
    addr2 = 32'h1001_0008; wdata2 = 32'h5566_7788; be2 = 4'b1111; wr2 = 1'b1;
    @(negedge clock);
    check("busy in wait", {31'h0, busy2}, 32'h1);
    #1 resetn = 1'b0;
    #1;
    check("abort busy", {31'h0, busy2}, 32'h0);
    check("abort ready", {31'h0, rdy2}, 32'h0);
    last2 = 32'h0;
    last0 = 32'h0;
    @(negedge clock);
    wr2 = 1'b0;
    resetn = 1'b1;
    check("readValue after reset", rv2, 32'h0);
    request(2, "ld word2 kept", 1'b1, 1'b0, 32'h1001_0008, 32'h0, 4'b1111, 32'h1122_3344, 1'b0);
    request(2, "st word2 again", 1'b0, 1'b1, 32'h1001_0008, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0);
    request(2, "ld word2 new", 1'b1, 1'b0, 32'h1001_0008, 32'h0, 4'b1111, 32'h0BAD_F00D, 1'b0);

    // zero wait states
    request(0, "w0 st", 1'b0, 1'b1, 32'h1001_0010, 32'hA5A5_A5A5, 4'b1111, 32'h0, 1'b0);
    request(0, "w0 ld", 1'b1, 1'b0, 32'h1001_0010, 32'h0, 4'b1111, 32'hA5A5_A5A5, 1'b0);
    request(0, "w0 st byte3", 1'b0, 1'b1, 32'h1001_0013, 32'h3C00_0000, 4'b1000, 32'h0, 1'b0);
    request(0, "w0 ld merged", 1'b1, 1'b0, 32'h1001_0010, 32'h0, 4'b1111, 32'h3CA5_A5A5, 1'b0);
    request(0, "w0 rd+wr", 1'b1, 1'b1, 32'h1001_0010, 32'h0, 4'b1111, 32'h0, 1'b1);
    request(0, "w0 ld after err", 1'b1, 1'b0, 32'h1001_0010, 32'h0, 4'b1111, 32'h3CA5_A5A5, 1'b0);

    repeat (4) @(negedge clock);
    check("w2 queue drained", q2.size(), 32'h0);
    check("w0 queue drained", q0.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
